// File: rtl/mult_unit.sv
// ---------------------------------------------------------------------------
// mult_unit -- sequential 32x32 signed multiplier, radix-2 Booth, one step per
// clock. A request is taken from IDLE, 32 Booth steps run in RUN, and the
// 64-bit product is published on hi/lo when the FSM enters DONE.
//
// Ports
//   clk    in   1   single clock, rising edge
//   reset  in   1   synchronous, active-low; clears all state
//   start  in   1   request pulse, only looked at in IDLE
//   A      in   32  multiplicand, signed two's complement
//   B      in   32  multiplier, signed two's complement
//   hi     out  32  upper half of the signed product (registered)
//   lo     out  32  lower half of the signed product (registered)
//   busy   out  1   high for the 32 cycles spent in RUN
//   done   out  1   one-cycle pulse when hi/lo first show a new result
// ---------------------------------------------------------------------------
module mult_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] a_q, a_d;
    // {partial product[64:33], multiplier bits[32:1], Booth guard bit[0]}
    logic signed [64:0] acc_q, acc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic signed [64:0] step_res;

    // One radix-2 Booth step followed by an arithmetic shift right. The
    // partial product is widened to 33 bits before add/subtract so that a
    // -2^31 multiplicand cannot overflow; dropping the guard bit of the
    // 66-bit intermediate leaves exactly the shifted 65-bit accumulator.
    function automatic logic signed [64:0] booth_step(
        input logic signed [64:0] acc,
        input logic signed [31:0] mcand
    );
        logic signed [32:0] part;
        logic signed [32:0] mc_ext;
        part   = $signed({acc[64], acc[64:33]});
        mc_ext = $signed({mcand[31], mcand});
        case (acc[1:0])
            2'b01:   part = part + mc_ext;
            2'b10:   part = part - mc_ext;
            default: part = part;
        endcase
        return $signed({part, acc[32:1]});
    endfunction

    always_comb begin
        step_res = booth_step(acc_q, a_q);
        state_d  = state_q;
        a_d      = a_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = $signed(A);
                    acc_d   = $signed({32'b0, B, 1'b0});
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                acc_d = step_res;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = step_res[64:33];
                    lo_d    = step_res[32:1];
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_unit -- self-checking bench for mult_unit. Expected products come
// from plain 64-bit signed multiplication; expected timing comes from the
// documented cycle schedule (busy for 32 cycles, done after the 32nd edge
// following the accepted start, low again after the 33rd).
// ---------------------------------------------------------------------------
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    mult_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return pa * pb;
    endfunction

    // Issue one operation with start sampled at "edge 0". inj = 1..33 pulses
    // start with A=B=9 at that edge, which must be ignored (RUN or DONE).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input int inj, input string tag);
        logic [63:0] exp;
        int nb;
        int nd;
        exp   = ref_prod(a, b);
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        nb = 0;
        nd = 0;
        for (int k = 0; k < 32; k++) begin
            if (inj == k + 1) begin
                start = 1'b1;
                A     = 32'd9;
                B     = 32'd9;
            end else begin
                start = 1'b0;
                A     = $urandom;
                B     = $urandom;
            end
            if (busy) nb++;
            if (done) nd++;
            tick();
        end
        chk({tag, " busy_cycles"}, 64'(nb), 64'd32);
        chk({tag, " early_done"}, 64'(nd), 64'd0);
        chk({tag, " done_at_32"}, 64'(done), 64'd1);
        chk({tag, " busy_at_32"}, 64'(busy), 64'd0);
        chk({tag, " product"}, {hi, lo}, exp);
        start = (inj == 33);
        if (inj == 33) begin
            A = 32'd9;
            B = 32'd9;
        end
        tick();
        start = 1'b0;
        chk({tag, " done_fall"}, 64'(done), 64'd0);
        if (inj >= 0) begin
            nb = 0;
            nd = 0;
            for (int k = 0; k < 40; k++) begin
                A = $urandom;
                B = $urandom;
                if (busy) nb++;
                if (done) nd++;
                tick();
            end
            chk({tag, " ignored_busy"}, 64'(nb), 64'd0);
            chk({tag, " ignored_done"}, 64'(nd), 64'd0);
            chk({tag, " idle_hold"}, {hi, lo}, exp);
        end
    endtask

    initial begin
        int nd;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b0;
        start = 1'b1;
        A     = 32'h1234_5678;
        B     = 32'h0000_0003;
        tick();
        tick();
        chk("reset hi_lo", {hi, lo}, 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);

        // First start accepted on the first edge with reset released.
        reset = 1'b1;
        do_op(32'd7, 32'd6, -1, "7x6");
        chk("7x6 literal", {hi, lo}, 64'h0000_0000_0000_002A);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, -1, "m1x1");
        chk("m1x1 literal", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(32'h8000_0000, 32'h8000_0000, -1, "minxmin");
        chk("minxmin literal", {hi, lo}, 64'h4000_0000_0000_0000);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, -1, "minxmax");
        chk("minxmax literal", {hi, lo}, 64'hC000_0000_8000_0000);
        do_op(32'd3, 32'd5, 10, "start_in_run");
        chk("start_in_run literal", {hi, lo}, 64'd15);
        do_op(32'hFFFF_FFF9, 32'd11, 33, "start_in_done");

        // Abort an in-flight operation at edge 15.
        A     = 32'd100;
        B     = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 15; k++) tick();
        reset = 1'b0;
        tick();
        chk("abort hi_lo", {hi, lo}, 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        reset = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) nd++;
            tick();
        end
        chk("abort no_done", 64'(nd), 64'd0);
        chk("abort hi_lo_after", {hi, lo}, 64'd0);
        chk("abort busy_after", 64'(busy), 64'd0);

        // Back-to-back random operands, a new start each time IDLE is reached.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 97 == 0) ra = 32'h8000_0000;
            if (i % 89 == 0) rb = 32'h8000_0000;
            do_op(ra, rb, -1, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL have no parameters; the operand width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse; SHALL be sampled only in IDLE.
REQ-005 A  input  32  multiplicand, signed two's complement (register-A operand path).
REQ-006 B  input  32  multiplier, signed two's complement (register-B operand path).
REQ-007 hi  output  32  upper 32 bits of the signed 64-bit product, registered.
REQ-008 lo  output  32  lower 32 bits of the signed 64-bit product, registered.
REQ-009 busy  output  1  high while a multiplication is in progress (state RUN).
REQ-010 done  output  1  one-cycle pulse; high in the cycle hi/lo first show a new result.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-012 IDLE -> RUN on a clk edge with start=1: latch A and B, load internal accumulator {32'b0, B, 1'b0}, clear the step counter to 0.
REQ-013 IDLE with start=0 SHALL hold IDLE; hi and lo SHALL hold their values.
REQ-014 RUN SHALL perform one radix-2 Booth step per cycle: examine acc[1:0]; 01 -> add latched A to acc[64:33]; 10 -> subtract latched A from acc[64:33]; 00/11 -> no add; then arithmetic-shift acc right by 1.
REQ-015 Booth add/subtract SHALL be performed at 33 bits (sign-extended) so 0x80000000 operands do not overflow.
REQ-016 The step counter SHALL increment once per RUN cycle; after step 31 completes, the FSM SHALL go RUN -> DONE.
REQ-017 On entry to DONE, hi SHALL equal acc[64:33] and lo SHALL equal acc[32:1]; hi and lo SHALL change only on this transition.
REQ-018 done SHALL be 1 only in DONE; DONE -> IDLE unconditionally on the next edge.
REQ-019 busy SHALL be 1 exactly in RUN (32 cycles per operation).
REQ-020 Latency: with start sampled at edge 0, done SHALL be 1 and hi/lo valid in the cycle after edge 32; done SHALL fall after edge 33.
REQ-021 start while in RUN or DONE SHALL be ignored; A and B changes after edge 0 SHALL NOT affect the result.
REQ-022 A back-to-back operation SHALL be accepted by start=1 at the edge leaving DONE only if it is re-sampled in IDLE; minimum issue interval is 34 cycles.
REQ-023 The result SHALL equal the exact signed 64-bit product for all operand pairs, including -2^31 * -2^31.

Reset
REQ-024 reset=0 at any clk edge SHALL force IDLE, hi=0, lo=0, busy=0, done=0, counter=0, acc=0, overriding start and any in-flight operation.
REQ-025 An operation aborted by reset SHALL NOT update hi/lo or pulse done after reset releases.
REQ-026 reset=0 for at least one edge SHALL suffice; first start is accepted at the first edge with reset=1.

Verification
REQ-027 A=7, B=6, start pulse at edge 0 -> busy=1 for 32 cycles, done=1 after edge 32, hi=0x00000000, lo=0x0000002A.
REQ-028 A=0xFFFFFFFF (-1), B=0x00000001 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
REQ-029 A=B=0x80000000 -> hi=0x40000000, lo=0x00000000; A=0x80000000, B=0x7FFFFFFF -> hi=0xC0000000, lo=0x80000000.
REQ-030 After start with A=3, B=5, pulse start with A=9, B=9 at edge 10 -> ignored; result hi=0, lo=15; done pulses once.
REQ-031 reset=0 at edge 15 of an operation (A=100, B=100) -> hi=lo=0, busy=done=0 next cycle, no done pulse afterward.
REQ-032 Random signed operand pairs (>=1000), back-to-back issue -> hi:lo matches the 64-bit signed reference product and done occurs exactly 33 cycles after each accepted start.
